// File: rtl/cpu_pkg.sv
// Shared CPU definitions: store/load size encodings and the store RMW sequencer state set.
package cpu_pkg;

    localparam logic [1:0] SZ_ILL  = 2'b00;
    localparam logic [1:0] SZ_WORD = 2'b01;
    localparam logic [1:0] SZ_HALF = 2'b10;
    localparam logic [1:0] SZ_BYTE = 2'b11;

    // One-hot so that every strobe output is a single flop bit (glitch-free).
    localparam int ST_IDLE_BIT    = 0;
    localparam int ST_READ_BIT    = 1;
    localparam int ST_CAPTURE_BIT = 2;
    localparam int ST_WRITE_BIT   = 3;
    localparam int ST_DONE_BIT    = 4;
    localparam int ST_ERR_BIT     = 5;

    typedef enum logic [5:0] {
        ST_IDLE    = 6'b000001,
        ST_READ    = 6'b000010,
        ST_CAPTURE = 6'b000100,
        ST_WRITE   = 6'b001000,
        ST_DONE    = 6'b010000,
        ST_ERR     = 6'b100000
    } rmw_state_t;

endpackage

// File: rtl/store_rmw_ctrl.sv
// Read-modify-write sequencer for sw/sh/sb: reads the target word, hands it to the
// store-size merge stage as base data, then writes the merged word back.
module store_rmw_ctrl
    import cpu_pkg::*;
#(
    parameter int READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] b_in,
    input  logic [31:0] mem_rdata,
    input  logic [31:0] ss_out,
    output logic [31:0] mem_addr,
    output logic        mem_wr,
    output logic [31:0] mem_wdata,
    output logic [1:0]  ss_control,
    output logic [31:0] mdr_out,
    output logic [31:0] b_out,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int         CNT_W    = 2;
    localparam logic [1:0] CNT_INIT = CNT_W'(READ_LATENCY - 1);

    rmw_state_t state_reg, state_next;
    logic [5:0]  state_bits;
    logic [31:0] addr_reg, b_reg, mdr_reg;
    logic [1:0]  size_reg;
    logic [1:0]  lat_cnt_reg;

    assign state_bits = state_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    case (size)
                        SZ_WORD:          state_next = ST_WRITE;
                        SZ_HALF, SZ_BYTE: state_next = ST_READ;
                        default:          state_next = ST_ERR;
                    endcase
                end
            end
            ST_READ:    state_next = (lat_cnt_reg == '0) ? ST_CAPTURE : ST_READ;
            ST_CAPTURE: state_next = ST_WRITE;
            ST_WRITE:   state_next = ST_DONE;
            ST_DONE:    state_next = ST_IDLE;
            ST_ERR:     state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy       = ~state_bits[ST_IDLE_BIT];
        mem_wr     = state_bits[ST_WRITE_BIT];
        done       = state_bits[ST_DONE_BIT];
        err        = state_bits[ST_ERR_BIT];
        ss_control = state_bits[ST_IDLE_BIT] ? SZ_ILL : size_reg;
        mem_addr   = addr_reg;
        mem_wdata  = ss_out;
        mdr_out    = mdr_reg;
        b_out      = b_reg;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_reg    <= '0;
            b_reg       <= '0;
            size_reg    <= SZ_ILL;
            mdr_reg     <= '0;
            lat_cnt_reg <= '0;
        end else begin
            if (state_reg == ST_IDLE && start) begin
                addr_reg <= addr;
                b_reg    <= b_in;
                size_reg <= size;
            end
            if (state_reg == ST_IDLE && state_next == ST_READ) begin
                lat_cnt_reg <= CNT_INIT;
            end else if (state_reg == ST_READ && lat_cnt_reg != '0) begin
                lat_cnt_reg <= lat_cnt_reg - 2'd1;
            end
            // Word stores never pass CAPTURE, so the previous base word is kept.
            if (state_reg == ST_CAPTURE) begin
                mdr_reg <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_store_rmw_ctrl.sv
// Scoreboard bench for store_rmw_ctrl: two instances (read latency 1 and 3) with a
// pipelined memory model and a loop-back merge model.
module tb_store_rmw_ctrl;

    localparam int K_WR = 1, K_DONE = 2, K_ERR = 3;

    typedef struct {
        int          kind;
        int          cyc;
        logic [31:0] data;
        logic [31:0] addr;
        logic [31:0] mdr;
        bit          chk_mdr;
    } ev_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  size;
    logic [31:0] addr, b_in;
    logic        start_s   [2];
    logic [31:0] rdata_s   [2];
    logic [31:0] ss_out_s  [2];
    logic [31:0] mem_addr_o[2];
    logic        mem_wr_o  [2];
    logic [31:0] wdata_o   [2];
    logic [1:0]  ss_ctl_o  [2];
    logic [31:0] mdr_o     [2];
    logic [31:0] b_out_o   [2];
    logic        busy_o    [2];
    logic        done_o    [2];
    logic        err_o     [2];

    logic [31:0] mem  [2][256];
    logic [31:0] pipe [2][4];
    int cyc = 0;
    int n_vec = 0;
    int n_mis = 0;
    ev_t q0[$];
    ev_t q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    store_rmw_ctrl #(.READ_LATENCY(1)) u_rl1 (
        .clk(clk), .reset(reset), .start(start_s[0]), .size(size), .addr(addr),
        .b_in(b_in), .mem_rdata(rdata_s[0]), .ss_out(ss_out_s[0]),
        .mem_addr(mem_addr_o[0]), .mem_wr(mem_wr_o[0]), .mem_wdata(wdata_o[0]),
        .ss_control(ss_ctl_o[0]), .mdr_out(mdr_o[0]), .b_out(b_out_o[0]),
        .busy(busy_o[0]), .done(done_o[0]), .err(err_o[0]));

    store_rmw_ctrl #(.READ_LATENCY(3)) u_rl3 (
        .clk(clk), .reset(reset), .start(start_s[1]), .size(size), .addr(addr),
        .b_in(b_in), .mem_rdata(rdata_s[1]), .ss_out(ss_out_s[1]),
        .mem_addr(mem_addr_o[1]), .mem_wr(mem_wr_o[1]), .mem_wdata(wdata_o[1]),
        .ss_control(ss_ctl_o[1]), .mdr_out(mdr_o[1]), .b_out(b_out_o[1]),
        .busy(busy_o[1]), .done(done_o[1]), .err(err_o[1]));

    function automatic logic [31:0] merge(input logic [1:0] c, input logic [31:0] base,
                                          input logic [31:0] b);
        case (c)
            2'b01:   return b;
            2'b10:   return {base[31:16], b[15:0]};
            2'b11:   return {base[31:8], b[7:0]};
            default: return 32'h0;
        endcase
    endfunction

    assign ss_out_s[0] = merge(ss_ctl_o[0], mdr_o[0], b_out_o[0]);
    assign ss_out_s[1] = merge(ss_ctl_o[1], mdr_o[1], b_out_o[1]);
    assign rdata_s[0]  = pipe[0][0];
    assign rdata_s[1]  = pipe[1][2];

    // Memory returns data N cycles after the address is presented; poison when idle.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            pipe[i][0] <= (busy_o[i] && !mem_wr_o[i]) ? mem[i][mem_addr_o[i][9:2]] : 32'hBAD0BAD0;
            for (int k = 1; k < 4; k++) pipe[i][k] <= pipe[i][k-1];
        end
    end

    task automatic push_ev(input int i, input int kind, input int c, input logic [31:0] d,
                           input logic [31:0] a, input logic [31:0] m, input bit cm);
        ev_t e;
        e.kind = kind; e.cyc = c; e.data = d; e.addr = a; e.mdr = m; e.chk_mdr = cm;
        if (i == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    task automatic chk_ev(input int i, input int kind, input logic [31:0] d,
                          input logic [31:0] a, input logic [31:0] m);
        ev_t e;
        bit  empty;
        empty = 1'b0;
        n_vec++;
        if (i == 0) begin
            if (q0.size() == 0) empty = 1'b1; else e = q0.pop_front();
        end else begin
            if (q1.size() == 0) empty = 1'b1; else e = q1.pop_front();
        end
        if (empty) begin
            n_mis++;
            $display("FAIL unexpected_event inst=%0d kind=%0d cyc=%0d got data=%h required no event",
                     i, kind, cyc, d);
        end else if (e.kind != kind || e.cyc != cyc ||
                     (kind == K_WR && (d !== e.data || a !== e.addr)) ||
                     (e.chk_mdr && m !== e.mdr)) begin
            n_mis++;
            $display("FAIL event inst=%0d got kind=%0d cyc=%0d data=%h addr=%h mdr=%h required kind=%0d cyc=%0d data=%h addr=%h mdr=%h",
                     i, kind, cyc, d, a, m, e.kind, e.cyc, e.data, e.addr, e.mdr);
        end else begin
            $display("ok event inst=%0d kind=%0d cyc=%0d data=%h", i, kind, cyc, d);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (mem_wr_o[i]) chk_ev(i, K_WR, wdata_o[i], mem_addr_o[i], mdr_o[i]);
                if (done_o[i])   chk_ev(i, K_DONE, 32'h0, mem_addr_o[i], mdr_o[i]);
                if (err_o[i])    chk_ev(i, K_ERR, 32'h0, mem_addr_o[i], mdr_o[i]);
            end
        end
    end

    task automatic chk_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s got %h required %h", name, act, exp);
        end else begin
            $display("ok %s = %h", name, act);
        end
    endtask

    // Called at a negedge; returns the cycle number during which the first post-accept
    // state is active (offset 1 from the accept edge).
    task automatic issue(input int i, input logic [1:0] sz, input logic [31:0] a,
                         input logic [31:0] b, output int acc);
        size = sz; addr = a; b_in = b; start_s[i] = 1'b1;
        acc = cyc + 1;
    endtask

    task automatic wait_idle(input int i);
        int n;
        n = 0;
        while (busy_o[i] && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (busy_o[i]) begin
            n_vec++; n_mis++;
            $display("FAIL idle_timeout inst=%0d got busy=1 required busy=0", i);
        end
        @(negedge clk);
    endtask

    task automatic do_store(input int i, input logic [1:0] sz, input logic [31:0] a,
                            input logic [31:0] b, input int wr_off, input logic [31:0] exp_d,
                            input bit cm, input logic [31:0] exp_m);
        int acc;
        issue(i, sz, a, b, acc);
        push_ev(i, K_WR, acc + wr_off - 1, exp_d, a, exp_m, cm);
        push_ev(i, K_DONE, acc + wr_off, 32'h0, a, exp_m, cm);
        @(negedge clk);
        start_s[i] = 1'b0;
        wait_idle(i);
    endtask

    initial begin
        int acc;
        int n;
        reset = 1'b1; start_s[0] = 1'b0; start_s[1] = 1'b0;
        size = 2'b00; addr = '0; b_in = '0;
        for (int i = 0; i < 2; i++)
            for (int k = 0; k < 256; k++) mem[i][k] = 32'h5A000000 | 32'(k);
        mem[0][8'h10] = 32'h11223344;
        mem[1][8'h20] = 32'hCAFEBABE;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk_eq($sformatf("rst_busy%0d", i), 32'(busy_o[i]), 32'h0);
            chk_eq($sformatf("rst_memwr%0d", i), 32'(mem_wr_o[i]), 32'h0);
            chk_eq($sformatf("rst_doneerr%0d", i), {30'h0, done_o[i], err_o[i]}, 32'h0);
            chk_eq($sformatf("rst_ssctl%0d", i), 32'(ss_ctl_o[i]), 32'h0);
            chk_eq($sformatf("rst_data%0d", i), mem_addr_o[i] | mdr_o[i] | b_out_o[i], 32'h0);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Word stores: write at offset 1, done at offset 2, no read phase.
        do_store(0, 2'b01, 32'h40, 32'hDEADBEEF, 1, 32'hDEADBEEF, 1'b0, 32'h0);
        do_store(1, 2'b01, 32'h80, 32'h0BADF00D, 1, 32'h0BADF00D, 1'b0, 32'h0);
        // Half/byte: write at READ_LATENCY+2, done at READ_LATENCY+3.
        do_store(0, 2'b10, 32'h40, 32'hAAAA5566, 3, 32'h11225566, 1'b1, 32'h11223344);
        do_store(1, 2'b11, 32'h80, 32'h000000FF, 5, 32'hCAFEBAFF, 1'b1, 32'hCAFEBABE);
        do_store(0, 2'b11, 32'h40, 32'h00000099, 3, 32'h11223399, 1'b1, 32'h11223344);
        do_store(1, 2'b10, 32'h80, 32'h12345678, 5, 32'hCAFE5678, 1'b1, 32'hCAFEBABE);

        // Illegal size: err one cycle, busy one cycle, no write.
        for (int i = 0; i < 2; i++) begin
            issue(i, 2'b00, 32'h44, 32'h1, acc);
            push_ev(i, K_ERR, acc, 32'h0, 32'h44, 32'h0, 1'b0);
            @(negedge clk);
            start_s[i] = 1'b0;
            chk_eq($sformatf("err_busy%0d", i), 32'(busy_o[i]), 32'h1);
            chk_eq($sformatf("err_memwr%0d", i), 32'(mem_wr_o[i]), 32'h0);
            @(negedge clk);
            chk_eq($sformatf("err_idle%0d", i), 32'(busy_o[i]), 32'h0);
            @(negedge clk);
        end

        // start held: ignored through the store and DONE, re-accepted in IDLE.
        issue(0, 2'b10, 32'h40, 32'hAAAA5566, acc);
        push_ev(0, K_WR, acc + 2, 32'h11225566, 32'h40, 32'h11223344, 1'b1);
        push_ev(0, K_DONE, acc + 3, 32'h0, 32'h40, 32'h11223344, 1'b1);
        n = 0;
        while (cyc != acc + 4 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk_eq("held_idle_busy", 32'(busy_o[0]), 32'h0);
        push_ev(0, K_WR, acc + 7, 32'h11225566, 32'h40, 32'h11223344, 1'b1);
        push_ev(0, K_DONE, acc + 8, 32'h0, 32'h40, 32'h11223344, 1'b1);
        @(negedge clk);
        start_s[0] = 1'b0;
        wait_idle(0);

        // Asynchronous reset during READ of a byte store.
        issue(1, 2'b11, 32'h80, 32'h000000FF, acc);
        @(negedge clk);
        start_s[1] = 1'b0;
        chk_eq("pre_rst_ssctl", 32'(ss_ctl_o[1]), 32'h3);
        #2 reset = 1'b1;
        #1;
        chk_eq("arst_busy", 32'(busy_o[1]), 32'h0);
        chk_eq("arst_memwr", 32'(mem_wr_o[1]), 32'h0);
        chk_eq("arst_ssctl", 32'(ss_ctl_o[1]), 32'h0);
        chk_eq("arst_mdr", mdr_o[1], 32'h0);
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        chk_eq("post_rst_busy", 32'(busy_o[1]), 32'h0);

        chk_eq("q0_drained", 32'(q0.size()), 32'h0);
        chk_eq("q1_drained", 32'(q1.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/store_rmw_ctrl.md
Name: store_rmw_ctrl

Overview:
Multicycle read-modify-write sequencer for sw/sh/sb stores. On a store request it reads the current memory word, holds it as the merge base, and drives the store-size merge stage with the size code, base word and register-B data. It then writes the merged word returned by that stage back to memory. It sits between the main control FSM and the memory port.

Parameters:
READ_LATENCY, 1, cycles from memory address valid to mem_rdata valid (legal range 1..4)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  store request; sampled only in IDLE
size  in  2  store size: 01 word, 10 half, 11 byte, 00 illegal
addr  in  32  store address; passed through unmodified
b_in  in  32  register-B store data
mem_rdata  in  32  memory read data
ss_out  in  32  merged word from the store-size merge stage
mem_addr  out  32  memory address; latched addr, held while busy
mem_wr  out  1  memory write strobe, high for exactly one cycle per legal store
mem_wdata  out  32  write data; equals ss_out
ss_control  out  2  size code to the merge stage; latched size while busy, 00 in IDLE
mdr_out  out  32  captured memory word, the merge-stage base data
b_out  out  32  latched b_in to the merge stage
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse on completion of a legal store
err  out  1  one-cycle pulse on a start with size 00

Behaviour:
- Reset (asynchronous): state IDLE. mem_wr=0, busy=0, done=0, err=0, ss_control=00, mem_addr/mdr_out/b_out=0, latency counter=0. A reset mid-operation aborts immediately; no write is issued afterwards.
- States: IDLE, READ, CAPTURE, WRITE, DONE, ERR.
- IDLE with start=1:
  - Latch addr, b_in and size.
  - size 01 goes to WRITE.
  - size 10 or 11 goes to READ.
  - size 00 goes to ERR.
  - start in any other state is ignored, including DONE and ERR.
- READ: mem_wr=0, mem_addr driven. Lasts exactly READ_LATENCY cycles (counter loads READ_LATENCY-1 on entry and decrements), then goes to CAPTURE.
- CAPTURE: one cycle. mem_rdata is registered into mdr_out at its closing edge. Next state is WRITE.
- WRITE: one cycle with mem_wr=1 and mem_wdata=ss_out (combinational pass-through), then DONE. Word stores skip READ/CAPTURE, so mdr_out keeps its previous value; the merge stage ignores it for word stores.
- DONE: done=1 for one cycle, busy still 1, then IDLE.
- ERR: err=1 for one cycle, no memory access, then IDLE.
- Latency from the start-accept edge to the done cycle:
  - word: 2 cycles.
  - half/byte: READ_LATENCY+3 cycles.
- All outputs decode from registered state and latched data; mem_wr must be glitch-free.
- No lane shifting: the merge replaces the low bits of the word only, and addr[1:0] is not interpreted here.

Decomposition:
- Shared package cpu_pkg:
  - size encodings SZ_WORD=01, SZ_HALF=10, SZ_BYTE=11, SZ_ILL=00 (shared with the merge stage and the load-size stage);
  - the store_rmw_ctrl state enum.
- No sub-module. The latency counter is inline. The merge stage is instantiated alongside this block at the datapath level, not inside it.

Test Plan:
- Word store: start, size=01, addr=0x40, b_in=0xDEADBEEF, ss_out loops back from a merge model -> mem_wr high 1 cycle after accept with mem_wdata=0xDEADBEEF; done 2 cycles after accept; no READ cycles.
- Half store, READ_LATENCY=1: memory[0x40]=0x11223344, b_in=0xAAAA5566 -> mdr_out=0x11223344; mem_wdata=0x11225566; mem_wr in cycle 3 after accept; done in cycle 4.
- Byte store, READ_LATENCY=3: memory word 0xCAFEBABE, b_in=0x000000FF -> mem_wdata=0xCAFEBAFF; done at cycle 6 after accept.
- Illegal size 00 -> err pulses 1 cycle; mem_wr stays 0; busy high 1 cycle; back in IDLE.
- start held high through a half store and in the DONE cycle -> only one store performed; a second start is accepted only once the FSM is back in IDLE.
- Reset asserted during READ of a byte store -> mem_wr=0, busy=0 and ss_control=00 immediately (asynchronously); no write occurs after reset deasserts.
